// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage: load extraction, load-data hold, write-back and forwarding buses
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_to_mem_valid,
    input  logic [73:0] ex_to_mem_bus,
    output logic        mem_allowin,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_allowin,
    output logic        mem_to_wb_valid,
    output logic [69:0] mem_to_wb_bus,
    output logic [38:0] mem_to_id_bus
);

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    logic        mem_valid;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        res_from_mem;
    logic [2:0]  ld_op;
    logic [31:0] rdata_buf;
    logic        rdata_buf_vld;

    logic        mem_ready_go;
    logic [31:0] ld_src;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] rf_wdata;

    assign mem_ready_go    = 1'b1;
    assign mem_allowin     = ~mem_valid | (mem_ready_go & wb_allowin);
    assign mem_to_wb_valid = mem_valid & mem_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid     <= 1'b0;
            pc            <= 32'h0;
            alu_result    <= 32'h0;
            rf_we         <= 1'b0;
            rf_waddr      <= 5'h0;
            res_from_mem  <= 1'b0;
            ld_op         <= 3'h0;
            rdata_buf     <= 32'h0;
            rdata_buf_vld <= 1'b0;
        end else begin
            if (mem_allowin) begin
                mem_valid <= ex_to_mem_valid;
            end
            if (ex_to_mem_valid && mem_allowin) begin
                {pc, alu_result, rf_we, rf_waddr, res_from_mem, ld_op} <= ex_to_mem_bus;
            end
            // Leaving clears the buffer so an instruction entering on the same edge reads live SRAM data.
            if (mem_valid && wb_allowin) begin
                rdata_buf_vld <= 1'b0;
            end else if (mem_valid && res_from_mem && !rdata_buf_vld) begin
                rdata_buf     <= data_sram_rdata;
                rdata_buf_vld <= 1'b1;
            end
        end
    end

    assign ld_src  = rdata_buf_vld ? rdata_buf : data_sram_rdata;
    assign ld_half = alu_result[1] ? ld_src[31:16] : ld_src[15:0];

    always_comb begin
        ld_byte = ld_src[7:0];
        case (alu_result[1:0])
            2'd1:    ld_byte = ld_src[15:8];
            2'd2:    ld_byte = ld_src[23:16];
            2'd3:    ld_byte = ld_src[31:24];
            default: ld_byte = ld_src[7:0];
        endcase
    end

    always_comb begin
        ld_data = ld_src;
        case (ld_op)
            LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            LD_BU:   ld_data = {24'h0, ld_byte};
            LD_HU:   ld_data = {16'h0, ld_half};
            LD_W:    ld_data = ld_src;
            default: ld_data = ld_src;
        endcase
    end

    assign rf_wdata = res_from_mem ? ld_data : alu_result;

    assign mem_to_wb_bus = {rf_we, rf_waddr, rf_wdata, pc};
    assign mem_to_id_bus = {rf_we & mem_valid, rf_waddr, rf_wdata, res_from_mem & mem_valid};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_to_mem_valid;
    logic [73:0] ex_to_mem_bus;
    logic        mem_allowin;
    logic [31:0] data_sram_rdata;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [69:0] mem_to_wb_bus;
    logic [38:0] mem_to_id_bus;

    int checks   = 0;
    int failures = 0;
    logic [69:0] sb[$];
    logic [69:0] exp_bus;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ex_to_mem_valid (ex_to_mem_valid),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .mem_allowin     (mem_allowin),
        .data_sram_rdata (data_sram_rdata),
        .wb_allowin      (wb_allowin),
        .mem_to_wb_valid (mem_to_wb_valid),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [73:0] mk_ex(input logic [31:0] pc, input logic [31:0] alu,
                                          input logic we, input logic [4:0] wa,
                                          input logic rfm, input logic [2:0] op);
        return {pc, alu, we, wa, rfm, op};
    endfunction

    function automatic logic [69:0] mk_wb(input logic we, input logic [4:0] wa,
                                          input logic [31:0] wd, input logic [31:0] pc);
        return {we, wa, wd, pc};
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: offered instruction and wb_allowin up front, scoreboard pop if a transfer
    // happens on the coming edge, then present SRAM data for whatever entered MEM on that edge.
    task automatic tick(input logic ev, input logic [73:0] bus, input logic wb,
                        input logic [31:0] rd, input logic push, input logic [69:0] exp);
        ex_to_mem_valid = ev;
        ex_to_mem_bus   = bus;
        wb_allowin      = wb;
        if (push) sb.push_back(exp);
        #1;
        if (mem_to_wb_valid && wb_allowin) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_transfer", mem_to_wb_bus, 70'h0);
            end else begin
                exp_bus = sb.pop_front();
                chk("sb_wb_bus", mem_to_wb_bus, exp_bus);
            end
        end
        @(posedge clk);
        #1 data_sram_rdata = rd;
        @(negedge clk);
    endtask

    initial begin
        resetn          = 1'b0;
        ex_to_mem_valid = 1'b0;
        ex_to_mem_bus   = '0;
        data_sram_rdata = 32'h0;
        wb_allowin      = 1'b1;
        #2;
        chk("rst_allowin", mem_allowin, 1);
        chk("rst_wb_valid", mem_to_wb_valid, 0);
        chk("rst_id_bus", mem_to_id_bus, 0);
        chk("rst_wb_bus", mem_to_wb_bus, 0);
        @(negedge clk);
        resetn = 1'b1;

        // ALU op
        tick(1, mk_ex(32'h1C000000, 32'h12345678, 1, 5, 0, 3'd0), 1, 32'h0,
             1, mk_wb(1, 5, 32'h12345678, 32'h1C000000));
        chk("alu_valid", mem_to_wb_valid, 1);
        chk("alu_bus", mem_to_wb_bus, {1'b1, 5'd5, 32'h12345678, 32'h1C000000});
        chk("alu_id_rfm", mem_to_id_bus[0], 0);

        // back-to-back loads with rdata 0x80FF7F01
        tick(1, mk_ex(32'h1C000004, 32'h00001003, 1, 6, 1, 3'd1), 1, 32'h80FF7F01,
             1, mk_wb(1, 6, 32'hFFFFFF80, 32'h1C000004));
        chk("ldb_id_rfm", mem_to_id_bus[0], 1);
        tick(1, mk_ex(32'h1C000008, 32'h00001003, 1, 7, 1, 3'd3), 1, 32'h80FF7F01,
             1, mk_wb(1, 7, 32'h00000080, 32'h1C000008));
        chk("ldbu_id_rfm", mem_to_id_bus[0], 1);
        tick(1, mk_ex(32'h1C00000C, 32'h00001002, 1, 8, 1, 3'd2), 1, 32'h80FF7F01,
             1, mk_wb(1, 8, 32'hFFFF80FF, 32'h1C00000C));
        tick(1, mk_ex(32'h1C000010, 32'h00001000, 1, 9, 1, 3'd4), 1, 32'h80FF7F01,
             1, mk_wb(1, 9, 32'h00007F01, 32'h1C000010));
        tick(1, mk_ex(32'h1C000014, 32'h00001000, 1, 10, 1, 3'd0), 1, 32'h80FF7F01,
             1, mk_wb(1, 10, 32'h80FF7F01, 32'h1C000014));
        chk("ldw_id_bus", mem_to_id_bus, {1'b1, 5'd10, 32'h80FF7F01, 1'b1});
        tick(1, mk_ex(32'h1C000018, 32'hA5A5A5A5, 0, 11, 0, 3'd0), 1, 32'h0,
             1, mk_wb(0, 11, 32'hA5A5A5A5, 32'h1C000018));
        chk("alu2_id_bus", mem_to_id_bus, {1'b0, 5'd11, 32'hA5A5A5A5, 1'b0});

        // load stalled by write-back while SRAM data changes
        tick(1, mk_ex(32'h1C00001C, 32'h00002000, 1, 12, 1, 3'd0), 1, 32'hCAFEF00D,
             1, mk_wb(1, 12, 32'hCAFEF00D, 32'h1C00001C));
        for (int i = 0; i < 3; i++) begin
            tick(0, '0, 0, 32'hDEADBEEF, 0, '0);
            chk("stall_wdata", mem_to_wb_bus[63:32], 32'hCAFEF00D);
            chk("stall_allowin", mem_allowin, 0);
        end
        tick(1, mk_ex(32'h1C000020, 32'h00002004, 1, 13, 1, 3'd0), 1, 32'h0BADF00D,
             1, mk_wb(1, 13, 32'h0BADF00D, 32'h1C000020));
        chk("post_stall_live", mem_to_wb_bus[63:32], 32'h0BADF00D);
        tick(0, '0, 1, 32'h0, 0, '0);
        chk("bubble_valid", mem_to_wb_valid, 0);
        chk("sb_drained", 70'(sb.size()), 0);

        // async reset in the middle of a stall
        tick(1, mk_ex(32'h1C000024, 32'h00003000, 1, 14, 1, 3'd0), 1, 32'h11223344, 0, '0);
        tick(0, '0, 0, 32'h55667788, 0, '0);
        chk("pre_rst_valid", mem_to_wb_valid, 1);
        chk("pre_rst_wdata", mem_to_wb_bus[63:32], 32'h11223344);
        #2 resetn = 1'b0;
        #1;
        chk("arst_allowin", mem_allowin, 1);
        chk("arst_wb_valid", mem_to_wb_valid, 0);
        chk("arst_wb_bus", mem_to_wb_bus, 0);
        chk("arst_id_bus", mem_to_id_bus, 0);
        @(negedge clk);
        resetn = 1'b1;
        chk("sb_final_empty", 70'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
